renkon_relu_sched: RTL and testbench

Layer-level sequencer for the renkon ReLU stage. It accepts the control stream from the upstream conv/accumulate stage and counts beats per output channel and per layer. It drives the ReLU enable, the bias/channel select and the output-buffer write port, each aligned to the D_RELU-deep datapath pipeline. It also frames `out_ctrl` for the next stage and reports completion and protocol errors to the layer controller.

---
 rtl/renkon_relu_sched_pkg.sv | 18 +
 rtl/renkon_relu_sched_if.sv | 9 +
 rtl/renkon_relu_sched_ctrl_delay.sv | 52 +++++
 rtl/renkon_relu_sched.sv | 151 +++++++++++++++
 tb/tb_renkon_relu_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/renkon_relu_sched_pkg.sv
// Shared types and constants for the renkon ReLU-stage sequencer.
package renkon_relu_sched_pkg;

   localparam int unsigned D_RELU = 2;

   typedef struct packed {
      logic start;
      logic valid;
      logic stop;
   } ctrl_reg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } relu_sched_state;

endpackage

// File: rtl/renkon_relu_sched_if.sv
// Start/valid/stop control bus between pipeline stages.
interface ctrl_bus;
   logic start;
   logic valid;
   logic stop;

   modport master (output start, output valid, output stop);
   modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/renkon_relu_sched_ctrl_delay.sv
// N-deep shift line for the control bundle plus its channel/address payload.
module renkon_ctrl_delay
   import renkon_relu_sched_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned CW = 10,
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          xrst,
   input  ctrl_reg       d_ctrl,
   input  logic [CW-1:0] d_chan,
   input  logic [AW-1:0] d_lin,
   output ctrl_reg       tap_m1_ctrl,
   output logic [CW-1:0] tap_m1_chan,
   output logic [AW-1:0] tap_m1_lin,
   output ctrl_reg       tap_n_ctrl,
   output logic [CW-1:0] tap_n_chan,
   output logic [AW-1:0] tap_n_lin
);

   ctrl_reg       ctrl_q [1:N];
   logic [CW-1:0] chan_q [1:N];
   logic [AW-1:0] lin_q  [1:N];

   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         for (int unsigned i = 1; i <= N; i++) begin
            ctrl_q[i] <= '0;
            chan_q[i] <= '0;
            lin_q[i]  <= '0;
         end
      end else begin
         ctrl_q[1] <= d_ctrl;
         chan_q[1] <= d_chan;
         lin_q[1]  <= d_lin;
         for (int unsigned i = 2; i <= N; i++) begin
            ctrl_q[i] <= ctrl_q[i-1];
            chan_q[i] <= chan_q[i-1];
            lin_q[i]  <= lin_q[i-1];
         end
      end
   end

   assign tap_m1_ctrl = ctrl_q[N-1];
   assign tap_m1_chan = chan_q[N-1];
   assign tap_m1_lin  = lin_q[N-1];
   assign tap_n_ctrl  = ctrl_q[N];
   assign tap_n_chan  = chan_q[N];
   assign tap_n_lin   = lin_q[N];

endmodule

// File: rtl/renkon_relu_sched.sv
// Layer sequencer for the ReLU stage: counts beats per channel/layer and drives
// ReLU enable, bias select and output-buffer writes aligned to the datapath.
module renkon_relu_sched
   import renkon_relu_sched_pkg::*;
#(
   parameter int unsigned D_RELU = renkon_relu_sched_pkg::D_RELU,
   parameter int unsigned LWIDTH = 10,
   parameter int unsigned ADDRW  = 12
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              req,
   input  logic [LWIDTH-1:0] cfg_n_out,
   input  logic [LWIDTH-1:0] cfg_img,
   ctrl_bus.slave            in_ctrl,
   ctrl_bus.master           out_ctrl,
   output logic              ack,
   output logic              relu_oe,
   output logic [LWIDTH-1:0] bias_sel,
   output logic              mem_we,
   output logic [ADDRW-1:0]  mem_addr,
   output logic              err
);

   localparam int unsigned FCW = $clog2(D_RELU + 1);

   relu_sched_state   state_q, state_d;
   logic [LWIDTH-1:0] n_out_q, n_out_d, img_q, img_d;
   logic [LWIDTH-1:0] pix_q, pix_d, chan_q, chan_d;
   logic [ADDRW-1:0]  lin_q, lin_d;
   logic [FCW-1:0]    fcnt_q, fcnt_d;
   logic              err_q, err_d;
   logic              last_beat;
   ctrl_reg           d_ctrl, tap1_ctrl, tapn_ctrl;
   logic [LWIDTH-1:0] tap1_chan, tapn_chan;
   logic [ADDRW-1:0]  tap1_lin, tapn_lin;
   logic              unused_taps;

   assign last_beat = (chan_q == n_out_q - LWIDTH'(1)) && (pix_q == img_q - LWIDTH'(1));

   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         state_q <= S_IDLE;
         n_out_q <= '0;
         img_q   <= '0;
         pix_q   <= '0;
         chan_q  <= '0;
         lin_q   <= '0;
         fcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_out_q <= n_out_d;
         img_q   <= img_d;
         pix_q   <= pix_d;
         chan_q  <= chan_d;
         lin_q   <= lin_d;
         fcnt_q  <= fcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_out_d = n_out_q;
      img_d   = img_q;
      pix_d   = pix_q;
      chan_d  = chan_q;
      lin_d   = lin_q;
      fcnt_d  = fcnt_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_ctrl.valid || in_ctrl.stop) err_d = 1'b1;
            if (req) begin
               n_out_d = cfg_n_out;
               img_d   = cfg_img;
               pix_d   = '0;
               chan_d  = '0;
               lin_d   = '0;
               err_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (in_ctrl.valid) begin
               lin_d = lin_q + ADDRW'(1);
               if (last_beat) begin
                  state_d = S_FLUSH;
                  fcnt_d  = '0;
               end else if (pix_q == img_q - LWIDTH'(1)) begin
                  pix_d  = '0;
                  chan_d = chan_q + LWIDTH'(1);
               end else begin
                  pix_d = pix_q + LWIDTH'(1);
               end
            end
            // A stop riding on the final beat is the normal end of layer.
            if (in_ctrl.stop && !(in_ctrl.valid && last_beat)) begin
               err_d   = 1'b1;
               state_d = S_FLUSH;
               fcnt_d  = '0;
            end
         end
         S_FLUSH: begin
            if (in_ctrl.valid || in_ctrl.stop) err_d = 1'b1;
            if (fcnt_q == FCW'(D_RELU - 1)) state_d = S_IDLE;
            else                           fcnt_d  = fcnt_q + FCW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      d_ctrl       = '0;
      d_ctrl.start = in_ctrl.start && (state_q == S_RUN);
      d_ctrl.valid = in_ctrl.valid && (state_q == S_RUN);
      d_ctrl.stop  = in_ctrl.stop  && (state_q == S_RUN);
   end

   renkon_ctrl_delay #(
      .N  (D_RELU),
      .CW (LWIDTH),
      .AW (ADDRW)
   ) u_delay (
      .clk         (clk),
      .xrst        (xrst),
      .d_ctrl      (d_ctrl),
      .d_chan      (chan_q),
      .d_lin       (lin_q),
      .tap_m1_ctrl (tap1_ctrl),
      .tap_m1_chan (tap1_chan),
      .tap_m1_lin  (tap1_lin),
      .tap_n_ctrl  (tapn_ctrl),
      .tap_n_chan  (tapn_chan),
      .tap_n_lin   (tapn_lin)
   );

   assign unused_taps    = ^{tap1_ctrl.start, tap1_ctrl.stop, tap1_lin, tapn_chan};

   assign ack            = (state_q == S_IDLE);
   assign err            = err_q;
   assign relu_oe        = tap1_ctrl.valid;
   assign bias_sel       = tap1_chan;
   assign mem_we         = tapn_ctrl.valid;
   assign mem_addr       = tapn_lin;
   assign out_ctrl.start = tapn_ctrl.start;
   assign out_ctrl.valid = tapn_ctrl.valid;
   assign out_ctrl.stop  = tapn_ctrl.stop;

endmodule

// File: tb/tb_renkon_relu_sched.sv
// Directed + randomized bench for renkon_relu_sched against a cycle-indexed reference model.
module tb_renkon_relu_sched;

   localparam int D  = 2;
   localparam int NC = 4096;

   logic       clk = 1'b0;
   logic       xrst;
   logic       req;
   logic [9:0] cfg_n_out, cfg_img;
   logic       ack, relu_oe, mem_we, err;
   logic [9:0] bias_sel;
   logic [11:0] mem_addr;

   ctrl_bus in_if ();
   ctrl_bus out_if ();

   renkon_relu_sched #(.D_RELU(D), .LWIDTH(10), .ADDRW(12)) dut (
      .clk       (clk),
      .xrst      (xrst),
      .req       (req),
      .cfg_n_out (cfg_n_out),
      .cfg_img   (cfg_img),
      .in_ctrl   (in_if),
      .out_ctrl  (out_if),
      .ack       (ack),
      .relu_oe   (relu_oe),
      .bias_sel  (bias_sel),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .err       (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model: expected outputs indexed by cycle number
   logic e_oe [0:NC-1];
   logic e_we [0:NC-1];
   logic e_os [0:NC-1];
   logic e_ov [0:NC-1];
   logic e_op [0:NC-1];
   int   e_bias [0:NC-1];
   int   e_addr [0:NC-1];
   int   now = 0;
   int   ms = 0;      // 0 idle, 1 run, 2 flush
   int   fl = 0;
   int   beats = 0;
   int   m_n = 0, m_img = 0;
   logic merr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, now, obs, exp_v);
      end
   endtask

   task automatic check_cycle();
      chk("ack", 32'(ack), 32'(ms == 0));
      chk("err", 32'(err), 32'(merr));
      chk("relu_oe", 32'(relu_oe), 32'(e_oe[now]));
      if (e_oe[now]) chk("bias_sel", 32'(bias_sel), 32'(e_bias[now]));
      chk("mem_we", 32'(mem_we), 32'(e_we[now]));
      if (e_we[now]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[now]));
      chk("out_start", 32'(out_if.start), 32'(e_os[now]));
      chk("out_valid", 32'(out_if.valid), 32'(e_ov[now]));
      chk("out_stop", 32'(out_if.stop), 32'(e_op[now]));
   endtask

   task automatic step(input logic r, input logic v, input logic s, input logic st);
      logic last;
      req = r; in_if.valid = v; in_if.stop = s; in_if.start = st;
      last = 1'b0;
      case (ms)
         0: begin
            if (v || s) merr = 1'b1;
            if (r) begin
               m_n = int'(cfg_n_out); m_img = int'(cfg_img);
               beats = 0; merr = 1'b0; ms = 1;
            end
         end
         1: begin
            e_os[now+D] = st; e_ov[now+D] = v; e_op[now+D] = s;
            if (v) begin
               e_oe[now+D-1]   = 1'b1;
               e_bias[now+D-1] = beats / m_img;
               e_we[now+D]     = 1'b1;
               e_addr[now+D]   = beats % 4096;
               beats++;
               if (beats == m_n * m_img) begin last = 1'b1; ms = 2; fl = D; end
            end
            if (s && !last) begin merr = 1'b1; ms = 2; fl = D; end
         end
         default: begin
            if (v || s) merr = 1'b1;
            fl--;
            if (fl == 0) ms = 0;
         end
      endcase
      @(posedge clk);
      now++;
      #1;
      req = 1'b0; in_if.valid = 1'b0; in_if.stop = 1'b0; in_if.start = 1'b0;
      check_cycle();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && ms != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic start_layer(input int n, input int img);
      cfg_n_out = 10'(n); cfg_img = 10'(img);
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mid_reset();
      xrst = 1'b1;
      #1;
      chk("rst_ack", 32'(ack), 32'd1);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_relu_oe", 32'(relu_oe), 32'd0);
      chk("rst_bias_sel", 32'(bias_sel), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_out_valid", 32'(out_if.valid), 32'd0);
      chk("rst_out_stop", 32'(out_if.stop), 32'd0);
      for (int i = now; i < now + 2*D + 4; i++) begin
         e_oe[i] = 0; e_we[i] = 0; e_os[i] = 0; e_ov[i] = 0; e_op[i] = 0;
      end
      ms = 0; merr = 1'b0; beats = 0;
      req = 1'b0; in_if.valid = 1'b0; in_if.stop = 1'b0; in_if.start = 1'b0;
      @(posedge clk);
      now++;
      #1;
      xrst = 1'b0;
      check_cycle();
   endtask

   initial begin
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < NC; i++) begin
         e_oe[i] = 0; e_we[i] = 0; e_os[i] = 0; e_ov[i] = 0; e_op[i] = 0;
         e_bias[i] = 0; e_addr[i] = 0;
      end
      xrst = 1'b1; req = 1'b0; cfg_n_out = '0; cfg_img = '0;
      in_if.valid = 1'b0; in_if.stop = 1'b0; in_if.start = 1'b0;
      #2;
      check_cycle();
      @(posedge clk);
      #1;
      xrst = 1'b0;

      // single-beat layer
      start_layer(1, 1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      wait_idle();

      // 3x4 contiguous, stop on the final beat, back-to-back req
      start_layer(3, 4);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'(i == 11), 1'(i == 0));
      wait_idle();

      // gapped valid 2x2
      start_layer(2, 2);
      for (int i = 0; i < 7; i++) step(1'b0, 1'(pat[i]), 1'b0, 1'b0);
      wait_idle();

      // early stop: 2x4, stop after 5 beats
      start_layer(2, 4);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      wait_idle();
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // stray traffic in IDLE, then req clears err; req during RUN is ignored
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      start_layer(2, 3);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      cfg_n_out = 10'd1; cfg_img = 10'd1;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      wait_idle();

      // reset during beat 3 of a 4x4 layer, then a fresh 1x2 layer
      start_layer(4, 4);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      in_if.valid = 1'b1;
      mid_reset();
      start_layer(1, 2);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // randomized layers with gapped valid and optional stop on the last beat
      for (int k = 0; k < 8; k++) begin
         start_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
         for (int i = 0; i < 80 && ms == 1; i++) begin
            logic v, s, st;
            v  = ($urandom_range(0, 9) < 6);
            s  = v && (beats + 1 == m_n * m_img) && ($urandom_range(0, 1) == 1);
            st = 1'($urandom_range(0, 1));
            step(1'b0, v, s, st);
         end
         wait_idle();
         if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0, 1'b0);
      end

      for (int i = 0; i < D + 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
